huffman_param: RTL

Parametrised Huffman encoder for the gray-level histogram path. It counts symbol occurrences over one frame and builds a Huffman tree with deterministic tie-breaking. It then emits a code word and a length mask per symbol. Compared with the fixed 6-symbol encoder, it adds configurable symbol count and widths, zero-count symbol exclusion, counter saturation, busy/overrun signalling and back-to-back frame support.

---
 rtl/huffman_param.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/huffman_param.sv
// Huffman encoder over a per-frame symbol histogram: counts values 1..NSYM, then performs one merge per cycle.
// Ties break on (weight, rank): leaves rank by symbol index, merged nodes after all leaves in creation order.
module huffman_param #(
  parameter int NSYM = 6,
  parameter int DW   = 8,
  parameter int CW   = 8,
  parameter int LW   = NSYM - 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                gray_valid,
  input  logic [DW-1:0]       gray_data,
  output logic                busy,
  output logic                overrun,
  output logic                bad_sym,
  output logic                CNT_valid,
  output logic [NSYM*CW-1:0]  cnt,
  output logic                cnt_sat,
  output logic                code_valid,
  output logic [NSYM*LW-1:0]  hc,
  output logic [NSYM*LW-1:0]  m
);
  localparam int NN   = 2*NSYM - 1;
  localparam int NW   = $clog2(NN);
  localparam int WW   = CW + 3;
  localparam int LENW = $clog2(NSYM);
  localparam int KW   = $clog2(NSYM+1);

  typedef enum logic [2:0] {IDLE, COUNT, LOAD, MERGE, DONE} state_t;
  state_t state_q, state_d;

  logic [CW-1:0]   cnt_q [NSYM];
  logic [CW-1:0]   cnt_d [NSYM];
  logic [LW-1:0]   hc_q  [NSYM];
  logic [LW-1:0]   hc_d  [NSYM];
  logic [LW-1:0]   m_q   [NSYM];
  logic [LW-1:0]   m_d   [NSYM];
  logic [LENW-1:0] len_q [NSYM];
  logic [LENW-1:0] len_d [NSYM];
  logic [NW-1:0]   grp_q [NSYM];
  logic [NW-1:0]   grp_d [NSYM];
  logic [WW-1:0]   w_q   [NN];
  logic [WW-1:0]   w_d   [NN];
  logic [NN-1:0]   alive_q, alive_d;
  logic [NW-1:0]   nxt_q, nxt_d;
  logic [KW-1:0]   rem_q, rem_d;
  logic [KW-1:0]   k;
  logic            gv_q, overrun_q, overrun_d, bad_q, bad_d, sat_q, sat_d;
  logic            start, take, in_rng;
  logic [NW-1:0]   a_idx, b_idx;
  logic            a_fnd, b_fnd;

  // A frame only opens on a rising edge of gray_valid, so a run overlapping busy never restarts counting.
  assign start  = (state_q == IDLE) && gray_valid && !gv_q;
  assign take   = start || ((state_q == COUNT) && gray_valid);
  assign in_rng = (gray_data != '0) && (gray_data <= DW'(NSYM));

  assign busy       = (state_q == LOAD) || (state_q == MERGE) || (state_q == DONE);
  assign code_valid = (state_q == DONE);
  assign CNT_valid  = (state_q == COUNT) && !gray_valid;
  assign overrun    = overrun_q;
  assign bad_sym    = bad_q;
  assign cnt_sat    = sat_q;

  for (genvar g = 0; g < NSYM; g++) begin : g_pack
    assign cnt[g*CW +: CW] = cnt_q[g];
    assign hc[g*LW +: LW]  = hc_q[g];
    assign m[g*LW +: LW]   = m_q[g];
  end

  // Two smallest live nodes; strict '<' in ascending node order keeps the lower rank on equal weight.
  always_comb begin
    a_idx = '0;
    b_idx = '0;
    a_fnd = 1'b0;
    b_fnd = 1'b0;
    for (int n = 0; n < NN; n++) begin
      if (alive_q[n] && (!a_fnd || (w_q[n] < w_q[a_idx]))) begin
        a_idx = NW'(n);
        a_fnd = 1'b1;
      end
    end
    for (int n = 0; n < NN; n++) begin
      if (alive_q[n] && (NW'(n) != a_idx) && (!b_fnd || (w_q[n] < w_q[b_idx]))) begin
        b_idx = NW'(n);
        b_fnd = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    nxt_d     = nxt_q;
    rem_d     = rem_q;
    alive_d   = alive_q;
    overrun_d = overrun_q | (gray_valid & busy);
    bad_d     = bad_q;
    sat_d     = sat_q;
    k         = '0;
    for (int i = 0; i < NSYM; i++) begin
      cnt_d[i] = cnt_q[i];
      hc_d[i]  = hc_q[i];
      m_d[i]   = m_q[i];
      len_d[i] = len_q[i];
      grp_d[i] = grp_q[i];
      k        = k + KW'(cnt_q[i] != '0);
    end
    for (int n = 0; n < NN; n++) w_d[n] = w_q[n];

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = COUNT;
          bad_d   = 1'b0;
          sat_d   = 1'b0;
          for (int i = 0; i < NSYM; i++) cnt_d[i] = '0;
        end
      end
      COUNT: if (!gray_valid) state_d = LOAD;
      LOAD: begin
        alive_d = '0;
        for (int i = 0; i < NSYM; i++) begin
          hc_d[i]    = '0;
          m_d[i]     = ((k == KW'(1)) && (cnt_q[i] != '0)) ? LW'(1) : '0;
          len_d[i]   = '0;
          grp_d[i]   = NW'(i);
          w_d[i]     = WW'(cnt_q[i]);
          alive_d[i] = (cnt_q[i] != '0);
        end
        nxt_d   = NW'(NSYM);
        rem_d   = k - KW'(1);
        state_d = (k < KW'(2)) ? DONE : MERGE;
      end
      MERGE: begin
        for (int i = 0; i < NSYM; i++) begin
          if ((grp_q[i] == a_idx) || (grp_q[i] == b_idx)) begin
            if (grp_q[i] == a_idx) hc_d[i] = hc_q[i] | (LW'(1) << len_q[i]);
            m_d[i]   = m_q[i] | (LW'(1) << len_q[i]);
            len_d[i] = len_q[i] + LENW'(1);
            grp_d[i] = nxt_q;
          end
        end
        w_d[nxt_q]     = w_q[a_idx] + w_q[b_idx];
        alive_d[a_idx] = 1'b0;
        alive_d[b_idx] = 1'b0;
        alive_d[nxt_q] = 1'b1;
        nxt_d          = nxt_q + NW'(1);
        rem_d          = rem_q - KW'(1);
        if (rem_q == KW'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (take) begin
      if (in_rng) begin
        for (int i = 0; i < NSYM; i++) begin
          if (gray_data == DW'(i+1)) begin
            if (cnt_d[i] != '1) cnt_d[i] = cnt_d[i] + CW'(1);
            if (cnt_d[i] == '1) sat_d = 1'b1;
          end
        end
      end else begin
        bad_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      nxt_q     <= '0;
      rem_q     <= '0;
      alive_q   <= '0;
      gv_q      <= 1'b0;
      overrun_q <= 1'b0;
      bad_q     <= 1'b0;
      sat_q     <= 1'b0;
      for (int i = 0; i < NSYM; i++) begin
        cnt_q[i] <= '0;
        hc_q[i]  <= '0;
        m_q[i]   <= '0;
        len_q[i] <= '0;
        grp_q[i] <= '0;
      end
      for (int n = 0; n < NN; n++) w_q[n] <= '0;
    end else begin
      state_q   <= state_d;
      nxt_q     <= nxt_d;
      rem_q     <= rem_d;
      alive_q   <= alive_d;
      gv_q      <= gray_valid;
      overrun_q <= overrun_d;
      bad_q     <= bad_d;
      sat_q     <= sat_d;
      for (int i = 0; i < NSYM; i++) begin
        cnt_q[i] <= cnt_d[i];
        hc_q[i]  <= hc_d[i];
        m_q[i]   <= m_d[i];
        len_q[i] <= len_d[i];
        grp_q[i] <= grp_d[i];
      end
      for (int n = 0; n < NN; n++) w_q[n] <= w_d[n];
    end
  end
endmodule
